reg_file_param: RTL

- Parametrised multi-entry register file for the pipelined datapath: two registered read ports, one write port.
- Optional write-to-read bypass, stall-hold of read outputs, and a configurable delay line on read port 2 for downstream operand buffering.
- Everything runs on the rising clock edge; there is no negedge read phase.
- Sits between decode (addresses) and the execute-stage operand registers.

---
 rtl/reg_file_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file, two registered read ports, one write port
// Optional write bypass, stall hold and a read port 2 delay line for operand buffering.
module reg_file_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 8,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0,
  parameter int ZERO_REG  = 0,
  parameter int BUF_DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] read_data2_buf
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] buf_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_d [BUF_DEPTH];

  logic              write_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rval  [2];

  // Out-of-range addresses never match a loop index, so they write nothing and read 0.
  always_comb begin
    write_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (reg_write && write_addr == ADDR_W'(i)) begin
        write_ok = 1'b1;
      end
    end
    if (ZERO_REG != 0 && write_addr == '0) begin
      write_ok = 1'b0;
    end
  end

  always_comb begin
    raddr[0] = read_addr1;
    raddr[1] = read_addr2;
    for (int p = 0; p < 2; p++) begin
      rval[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr[p] == ADDR_W'(i)) begin
          rval[p] = mem_q[i];
        end
      end
      if (BYPASS != 0 && write_ok && write_addr == raddr[p]) begin
        rval[p] = write_data;
      end
      if (ZERO_REG != 0 && raddr[p] == '0) begin
        rval[p] = '0;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (write_ok && write_addr == ADDR_W'(i)) begin
        mem_d[i] = write_data;
      end
    end
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    buf_d = buf_q;
    if (!stall) begin
      rd1_d    = rval[0];
      rd2_d    = rval[1];
      buf_d[0] = rd2_q;
      for (int k = 1; k < BUF_DEPTH; k++) begin
        buf_d[k] = buf_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (INIT_MODE != 0 && !(ZERO_REG != 0 && i == 0)) begin
          mem_q[i] <= DATA_W'(i);
        end else begin
          mem_q[i] <= '0;
        end
      end
      rd1_q <= '0;
      rd2_q <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      buf_q <= buf_d;
    end
  end

  assign read_data1     = rd1_q;
  assign read_data2     = rd2_q;
  assign read_data2_buf = buf_q[BUF_DEPTH-1];

endmodule
